acc_bank: RTL and testbench
===========================

# acc_bank

Parametrised successor to the datapath accumulator. It holds NUM_ACC accumulators of WIDTH bits and loads any one of them from a zero- or sign-extended immediate, from `reg_out`, or from the ALU `result`. It also performs multi-cycle shift and rotate operations at one bit per cycle behind a valid/ready handshake. It sits between the register file / ALU and the register-file write port, and drives `regIn` as before.

## Interface
- `WIDTH`, 8: accumulator and data width, ≥ 4.
- `IMM_W`, 4: immediate width, < WIDTH.
- `NUM_ACC`, 4: number of accumulators, power of two, ≥ 2.
- `SEL_W`, $clog2(NUM_ACC): accumulator index width (derived).
- `SH_W`, $clog2(WIDTH)+1: shift-amount width (derived).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `CLB`  in  1  synchronous active-high reset.
- `op_valid`  in  1  operation request.
- `op_ready`  out  1  block accepts an op this cycle.
- `op`  in  3  opcode: 000 NOP, 001 LDI, 010 LDR, 011 LDS, 100 SHL, 101 SHR, 110 ASR, 111 ROL.
- `acc_sel`  in  SEL_W  target accumulator of the op.
- `imm`  in  IMM_W  immediate for LDI.
- `imm_sext`  in  1  LDI: 1 = sign-extend, 0 = zero-extend.
- `reg_out`  in  WIDTH  register-file read data (LDR).
- `result`  in  WIDTH  ALU result (LDS).
- `shamt`  in  SH_W  shift count, 0..WIDTH.
- `rd_sel`  in  SEL_W  accumulator driven onto `regIn`.
- `regIn`  out  WIDTH  contents of acc[`rd_sel`] (combinational read of registered state).
- `zero`  out  1  `regIn` == 0.
- `carry`  out  1  last bit shifted or rotated out (registered).
- `busy`  out  1  shift in progress; equals !`op_ready`.

## Operation
- Accept an op when `op_valid` && `op_ready`. Inputs are sampled only on the accept edge.
- Accepting NUM_ACC-1 then index 0 each needs only the target accumulator to be legal.
- LDI writes `acc[acc_sel]` = {ext, imm}, where ext is all zeros, or copies of `imm[IMM_W-1]` when `imm_sext` = 1.
- LDR writes `reg_out`. LDS writes `result`. Each is one cycle; the block stays IDLE.
- NOP: no state change.
- Shift ops (SHL, SHR logical, ASR arithmetic, ROL):
  - Latch `acc_sel`, `op` and `shamt` into internal registers.
  - Go to SHIFT and apply one 1-bit step per cycle to the latched accumulator, `shamt` times.
  - For SHL, SHR and ASR, `carry` gets each shifted-out bit, so it ends holding the last one.
  - For ROL, `carry` gets the bit that wrapped (old MSB).
- `shamt` = 0: no SHIFT state. The op completes on the accept edge; value and `carry` are unchanged.
- `shamt` > WIDTH: clamp to WIDTH.
  - SHL/SHR: result 0.
  - ASR: result is all sign bits.
  - ROL by WIDTH: value unchanged, and `carry` = original LSB.
- `carry` is changed only by shift ops; loads leave it.
- Reading during SHIFT: `regIn` shows the intermediate value when `rd_sel` equals the shifting accumulator. Other accumulators read normally.
- FSM states: IDLE and SHIFT.
  - IDLE → SHIFT on accepting a shift op with `shamt` ≠ 0.
  - SHIFT → IDLE on the cycle the remaining count reaches 0.
  - No other transitions.
- `op_valid` while busy is ignored: not queued, not acted on.

## Timing
- Reset (`CLB` = 1 at an edge):
  - all accumulators 0, `carry` 0, state IDLE, counter 0;
  - therefore `regIn` = 0, `zero` = 1, `op_ready` = 1, `busy` = 0.
- Reset mid-shift aborts the op. The partial value is discarded (accumulator cleared).
- Load latency: written value appears on `regIn` in the cycle after the accept edge.
- Shift of n bits (1 ≤ n ≤ WIDTH):
  - accept at edge 0, `busy` high from edge 0 to edge n;
  - first step at edge 1, final value and `carry` visible after edge n;
  - `op_ready` high again after edge n, so the next op can be accepted at edge n+1.
  - Throughput is 1 op per n+1 cycles.
- Back-to-back loads: one per cycle, no bubbles.
- Loads to the same accumulator on consecutive cycles: the later one wins on its own edge.
- `rd_sel` change is reflected on `regIn`/`zero` combinationally, with no added latency.

## Structure
- Package `acc_pkg`:
  - `acc_op_e` enum (the eight opcodes);
  - `acc_state_e` {IDLE, SHIFT};
  - the helper function for immediate extension.
- Sub-module `acc_shift_step`: combinational 1-bit shifter taking value, op, WIDTH → next value, out-bit. Instantiated once, on the latched accumulator.
- Accumulator array, FSM, down-counter and `carry` register live in the top.

## Test plan
- Reset, then read every `rd_sel` → `regIn` = 0x00, `zero` = 1, `carry` = 0, `op_ready` = 1.
- LDI into acc1: `imm` = 0xA, `imm_sext` = 1 → 0xFA. Same with `imm_sext` = 0 into acc2 → 0x0A. Next cycle, `rd_sel` = 1/2 reads 0xFA/0x0A.
- LDR `reg_out` = 0x81 into acc0, then SHL `shamt` = 3 → `busy` for 3 cycles, final 0x08, `carry` = 0. Then ROL `shamt` = 1 on 0x81 → 0x03, `carry` = 1.
- ASR acc3 = 0x90 by `shamt` = 9 (clamped to 8) → 0xFF after 8 steps. During busy, `op_valid` with LDS is ignored and no accumulator changes.
- Shift with `shamt` = 0 → `op_ready` stays 1, value and `carry` unchanged. LDS `result` = 0x55 on the next cycle is accepted.
- Assert `CLB` at step 2 of a 6-step SHR → next cycle all accumulators 0, `carry` 0, IDLE, `op_ready` = 1.

Source files
------------

// File: rtl/acc_bank_pkg.sv
// acc_pkg: shared types and helpers for the acc_bank accumulator block.
//   acc_op_e     - the eight opcodes accepted on the op port
//   acc_state_e  - control FSM states (IDLE, SHIFT)
//   acc_ext_imm  - zero/sign extension of an immediate to a 64-bit container
package acc_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LDI = 3'b001,
        OP_LDR = 3'b010,
        OP_LDS = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101,
        OP_ASR = 3'b110,
        OP_ROL = 3'b111
    } acc_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } acc_state_e;

    // Extends the low imm_w bits of imm into a 64-bit value. Callers truncate
    // to their own width, so the accumulator width must not exceed 64.
    function automatic logic [63:0] acc_ext_imm(input logic [63:0] imm,
                                                input int          imm_w,
                                                input logic        sext);
        logic [63:0] r;
        logic        fill;
        r    = 64'd0;
        fill = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i == imm_w - 1) begin
                fill = sext & imm[i];
            end
        end
        for (int i = 0; i < 64; i++) begin
            r[i] = (i < imm_w) ? imm[i] : fill;
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_bank_shift_step.sv
// acc_shift_step: combinational single-bit shifter/rotator.
//   i_value - current accumulator value
//   i_op    - shift opcode (SHL, SHR, ASR, ROL); anything else passes through
//   o_next  - value after one 1-bit step
//   o_out   - bit shifted out (or, for ROL, the bit that wrapped around)
module acc_shift_step
    import acc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_value,
    input  acc_op_e          i_op,
    output logic [WIDTH-1:0] o_next,
    output logic             o_out
);

    // One step of the selected shift or rotate.
    always_comb begin
        o_next = i_value;
        o_out  = 1'b0;
        case (i_op)
            OP_SHL: begin
                o_next = {i_value[WIDTH-2:0], 1'b0};
                o_out  = i_value[WIDTH-1];
            end
            OP_SHR: begin
                o_next = {1'b0, i_value[WIDTH-1:1]};
                o_out  = i_value[0];
            end
            OP_ASR: begin
                o_next = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
                o_out  = i_value[0];
            end
            OP_ROL: begin
                o_next = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
                o_out  = i_value[WIDTH-1];
            end
            default: begin
                o_next = i_value;
                o_out  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/acc_bank.sv
// acc_bank: bank of NUM_ACC accumulators with single-cycle loads and
// bit-serial (one bit per cycle) shift/rotate operations.
//   clk, CLB          - clock, synchronous active-high reset
//   op_valid/op_ready - op handshake; busy is the inverse of op_ready
//   op, acc_sel       - opcode and target accumulator
//   imm, imm_sext     - LDI immediate and its extension mode
//   reg_out, result   - LDR / LDS load data
//   shamt             - shift count (values above WIDTH act as WIDTH)
//   rd_sel, regIn     - combinational read port of the accumulator array
//   zero              - regIn is all zeros
//   carry             - last bit shifted/rotated out
module acc_bank
    import acc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int IMM_W   = 4,
    parameter int NUM_ACC = 4,
    parameter int SEL_W   = $clog2(NUM_ACC),
    parameter int SH_W    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             CLB,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [SEL_W-1:0] acc_sel,
    input  logic [IMM_W-1:0] imm,
    input  logic             imm_sext,
    input  logic [WIDTH-1:0] reg_out,
    input  logic [WIDTH-1:0] result,
    input  logic [SH_W-1:0]  shamt,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [WIDTH-1:0] regIn,
    output logic             zero,
    output logic             carry,
    output logic             busy
);

    logic [WIDTH-1:0] r_acc [NUM_ACC];
    acc_state_e       r_state;
    acc_state_e       w_state_nxt;
    logic [SH_W-1:0]  r_cnt;
    logic [SEL_W-1:0] r_sel;
    acc_op_e          r_op;
    logic             r_carry;

    acc_op_e          w_op;
    logic             w_accept;
    logic             w_is_shift;
    logic [SH_W-1:0]  w_shamt;
    logic [WIDTH-1:0] w_ext;
    logic [WIDTH-1:0] w_step_next;
    logic             w_step_out;

    assign w_op       = acc_op_e'(op);
    assign op_ready   = (r_state == ST_IDLE);
    assign busy       = ~op_ready;
    assign w_accept   = op_valid & op_ready;
    // All shift/rotate opcodes have the MSB set.
    assign w_is_shift = op[2];
    // Shifting further than WIDTH gives the same result as shifting WIDTH.
    assign w_shamt    = (shamt > SH_W'(WIDTH)) ? SH_W'(WIDTH) : shamt;
    assign w_ext      = WIDTH'(acc_ext_imm(64'(imm), IMM_W, imm_sext));

    // The accumulator being shifted shows its intermediate value here.
    assign regIn = r_acc[rd_sel];
    assign zero  = (regIn == {WIDTH{1'b0}});
    assign carry = r_carry;

    acc_shift_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .i_value (r_acc[r_sel]),
        .i_op    (r_op),
        .o_next  (w_step_next),
        .o_out   (w_step_out)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (CLB) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_shift && (w_shamt != {SH_W{1'b0}})) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // The last step happens on this edge, so leave SHIFT with it.
                if (r_cnt == SH_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Accumulator array, shift bookkeeping and carry.
    always_ff @(posedge clk) begin
        if (CLB) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                r_acc[i] <= {WIDTH{1'b0}};
            end
            r_carry <= 1'b0;
            r_cnt   <= {SH_W{1'b0}};
            r_sel   <= {SEL_W{1'b0}};
            r_op    <= OP_NOP;
        end else if (w_accept) begin
            case (w_op)
                OP_LDI: r_acc[acc_sel] <= w_ext;
                OP_LDR: r_acc[acc_sel] <= reg_out;
                OP_LDS: r_acc[acc_sel] <= result;
                OP_SHL, OP_SHR, OP_ASR, OP_ROL: begin
                    // A zero count latches but never enters SHIFT, so nothing moves.
                    r_sel <= acc_sel;
                    r_op  <= w_op;
                    r_cnt <= w_shamt;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end else if (r_state == ST_SHIFT) begin
            r_acc[r_sel] <= w_step_next;
            r_carry      <= w_step_out;
            r_cnt        <= r_cnt - SH_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: tb/tb_acc_bank.sv
module tb_acc_bank;
    import acc_pkg::*;

    localparam int W  = 8;
    localparam int IW = 4;
    localparam int NA = 4;
    localparam int SW = 2;
    localparam int HW = 4;

    logic          clk = 1'b0;
    logic          CLB;
    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op;
    logic [SW-1:0] acc_sel;
    logic [IW-1:0] imm;
    logic          imm_sext;
    logic [W-1:0]  reg_out;
    logic [W-1:0]  result;
    logic [HW-1:0] shamt;
    logic [SW-1:0] rd_sel;
    logic [W-1:0]  regIn;
    logic          zero;
    logic          carry;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] m_acc [NA];
    logic       m_carry;

    always #5 clk = ~clk;

    acc_bank #(.WIDTH(W), .IMM_W(IW), .NUM_ACC(NA)) dut (
        .clk      (clk),
        .CLB      (CLB),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .acc_sel  (acc_sel),
        .imm      (imm),
        .imm_sext (imm_sext),
        .reg_out  (reg_out),
        .result   (result),
        .shamt    (shamt),
        .rd_sel   (rd_sel),
        .regIn    (regIn),
        .zero     (zero),
        .carry    (carry),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_ext(input logic [3:0] im, input logic sx);
        return sx ? {{4{im[3]}}, im} : {4'h0, im};
    endfunction

    // Whole-operation result of shifting v by n (1..8) bits.
    task automatic m_shift(input logic [2:0] o, input logic [7:0] v, input int n,
                           output logic [7:0] r, output logic c);
        logic [15:0] t;
        case (o)
            3'd4: begin t = {8'h00, v} << n;      r = t[7:0]; c = v[8-n]; end
            3'd5: begin t = {8'h00, v} >> n;      r = t[7:0]; c = v[n-1]; end
            3'd6: begin t = {{8{v[7]}}, v} >> n;  r = t[7:0]; c = v[n-1]; end
            default: begin t = {v, v} >> (8 - n); r = t[7:0]; c = v[8-n]; end
        endcase
    endtask

    task automatic check_all();
        for (int s = 0; s < NA; s++) begin
            rd_sel = SW'(s);
            #1;
            chk($sformatf("regIn[%0d]", s), 32'(regIn), 32'(m_acc[s]));
            chk($sformatf("zero[%0d]", s), 32'(zero), 32'(m_acc[s] == 8'h00));
        end
        chk("carry", 32'(carry), 32'(m_carry));
        chk("op_ready", 32'(op_ready), 32'd1);
        chk("busy", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [2:0] o, input int sel, input logic [3:0] im,
                          input logic sx, input logic [7:0] ro, input logic [7:0] rs,
                          input logic [3:0] sa, input bit intrude);
        int         n;
        logic [7:0] v0;
        logic [7:0] r;
        logic       c;
        @(negedge clk);
        op = o; acc_sel = SW'(sel); imm = im; imm_sext = sx;
        reg_out = ro; result = rs; shamt = sa; rd_sel = SW'(sel);
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        case (o)
            3'd1: m_acc[sel] = m_ext(im, sx);
            3'd2: m_acc[sel] = ro;
            3'd3: m_acc[sel] = rs;
            3'd4, 3'd5, 3'd6, 3'd7: begin
                n  = (sa > 4'd8) ? 8 : int'(sa);
                v0 = m_acc[sel];
                if (n == 0) begin
                    chk("ready_shamt0", 32'(op_ready), 32'd1);
                end else begin
                    for (int k = 1; k <= n; k++) begin
                        chk("busy_step", 32'(busy), 32'd1);
                        chk("ready_step", 32'(op_ready), 32'd0);
                        if (intrude && k == 2) begin
                            op = 3'd3; acc_sel = SW'((sel + 1) % NA);
                            result = 8'hEE; op_valid = 1'b1;
                        end
                        @(posedge clk);
                        #1;
                        op_valid = 1'b0;
                        m_shift(o, v0, k, r, c);
                        chk("partial_val", 32'(regIn), 32'(r));
                        chk("partial_carry", 32'(carry), 32'(c));
                    end
                    m_acc[sel] = r;
                    m_carry    = c;
                end
            end
            default: ;
        endcase
        check_all();
    endtask

    initial begin
        CLB = 1'b1; op_valid = 1'b0; op = 3'd0; acc_sel = '0; imm = '0;
        imm_sext = 1'b0; reg_out = '0; result = '0; shamt = '0; rd_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        CLB = 1'b0;
        for (int i = 0; i < NA; i++) m_acc[i] = 8'h00;
        m_carry = 1'b0;
        check_all();

        // Immediate loads, sign- and zero-extended.
        run_op(3'd1, 1, 4'hA, 1'b1, 8'h00, 8'h00, 4'd0, 1'b0);
        run_op(3'd1, 2, 4'hA, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
        rd_sel = 2'd1; #1; chk("ldi_sext", 32'(regIn), 32'h0FA);
        rd_sel = 2'd2; #1; chk("ldi_zext", 32'(regIn), 32'h00A);

        // SHL by 3 and ROL by 1 of 0x81.
        run_op(3'd2, 0, 4'h0, 1'b0, 8'h81, 8'h00, 4'd0, 1'b0);
        run_op(3'd4, 0, 4'h0, 1'b0, 8'h00, 8'h00, 4'd3, 1'b0);
        rd_sel = 2'd0; #1; chk("shl3_val", 32'(regIn), 32'h08);
        chk("shl3_carry", 32'(carry), 32'd0);
        run_op(3'd2, 0, 4'h0, 1'b0, 8'h81, 8'h00, 4'd0, 1'b0);
        run_op(3'd7, 0, 4'h0, 1'b0, 8'h00, 8'h00, 4'd1, 1'b0);
        rd_sel = 2'd0; #1; chk("rol1_val", 32'(regIn), 32'h03);
        chk("rol1_carry", 32'(carry), 32'd1);

        // Clamped ASR with an ignored LDS while busy.
        run_op(3'd2, 3, 4'h0, 1'b0, 8'h90, 8'h00, 4'd0, 1'b0);
        run_op(3'd6, 3, 4'h0, 1'b0, 8'h00, 8'h00, 4'd9, 1'b1);
        rd_sel = 2'd3; #1; chk("asr9_val", 32'(regIn), 32'hFF);

        // Zero-count shift, then an immediate LDS.
        run_op(3'd4, 1, 4'h0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
        run_op(3'd3, 2, 4'h0, 1'b0, 8'h00, 8'h55, 4'd0, 1'b0);
        rd_sel = 2'd2; #1; chk("lds_after_sh0", 32'(regIn), 32'h55);

        // ROL by a full width keeps the value, carry = original LSB.
        run_op(3'd2, 1, 4'h0, 1'b0, 8'hA5, 8'h00, 4'd0, 1'b0);
        run_op(3'd7, 1, 4'h0, 1'b0, 8'h00, 8'h00, 4'd8, 1'b0);
        rd_sel = 2'd1; #1; chk("rol8_val", 32'(regIn), 32'hA5);
        chk("rol8_carry", 32'(carry), 32'd1);

        // Reset in the middle of a 6-step SHR.
        run_op(3'd2, 2, 4'h0, 1'b0, 8'hC3, 8'h00, 4'd0, 1'b0);
        @(negedge clk);
        op = 3'd5; acc_sel = 2'd2; shamt = 4'd6; op_valid = 1'b1;
        @(posedge clk); #1; op_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        CLB = 1'b1;
        @(posedge clk); #1;
        CLB = 1'b0;
        for (int i = 0; i < NA; i++) m_acc[i] = 8'h00;
        m_carry = 1'b0;
        check_all();

        // Random operations against the model.
        for (int t = 0; t < 60; t++) begin
            run_op(3'($urandom_range(0, 7)), int'($urandom_range(0, NA - 1)),
                   4'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                   4'($urandom_range(0, 11)), bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
